// File: rtl/vram_writer.sv
// vram_writer: host write/fill/read engine for dpmem port 1.
// Optional VRAM_WRITER_VBLANK_GATE_EN: strobes only while I_vid_blank=1.
module vram_writer #(
    parameter int P_data_bits = 8,
    parameter int P_addr_bits = 12
) (
    input  logic                   I_clock,
    input  logic                   I_reset,
    input  logic                   I_cmd_valid,
    output logic                   O_cmd_ready,
    input  logic [1:0]             I_cmd_op,
    input  logic [P_addr_bits-1:0] I_cmd_addr,
    input  logic [P_data_bits-1:0] I_cmd_data,
    input  logic [P_addr_bits-1:0] I_cmd_count,
    output logic                   O_rsp_valid,
    output logic [P_data_bits-1:0] O_rsp_data,
    output logic                   O_busy,
`ifdef VRAM_WRITER_VBLANK_GATE_EN
    input  logic                   I_vid_blank,
`endif
    output logic                   O_mem_clock,
    output logic [P_addr_bits-1:0] O_mem_addr,
    output logic                   O_mem_wren,
    output logic                   O_mem_rden,
    output logic [P_data_bits-1:0] O_mem_data,
    input  logic [P_data_bits-1:0] I_mem_data
);

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_FILL  = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [P_addr_bits-1:0] ONE  = 1;
    localparam logic [P_addr_bits-1:0] ZERO = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_FILL,
        S_RD,
        S_RD_WAIT
    } state_t;

    state_t state_q, state_d;

    logic [P_addr_bits-1:0] addr_q, addr_d;
    logic [P_addr_bits-1:0] rem_q, rem_d;
    logic [P_data_bits-1:0] data_q, data_d;
    logic [P_data_bits-1:0] rsp_data_q, rsp_data_d;
    logic wren_q, wren_d;
    logic rden_q, rden_d;
    logic ready_q, ready_d;
    logic rsp_valid_q, rsp_valid_d;
    logic accept;
    logic go;

`ifdef VRAM_WRITER_VBLANK_GATE_EN
    assign go = I_vid_blank;
`else
    assign go = 1'b1;
`endif

    assign accept = I_cmd_valid & ready_q;

    // State register; reset aborts any command in flight
    always_ff @(posedge I_clock) begin
        if (I_reset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state: a stalled (gated) cycle holds the current state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    unique case (I_cmd_op)
                        OP_WRITE: state_d = S_WR;
                        OP_FILL:  state_d = (I_cmd_count != ZERO) ? S_FILL : S_IDLE;
                        OP_READ:  state_d = S_RD;
                        default:  state_d = S_IDLE;
                    endcase
                end
            end
            S_WR:      if (go) state_d = S_IDLE;
            S_FILL:    if (go && rem_q == ONE) state_d = S_IDLE;
            S_RD:      if (go) state_d = S_RD_WAIT;
            S_RD_WAIT: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values; strobes follow the next state so they are registered
    always_comb begin
        addr_d      = addr_q;
        data_d      = data_q;
        rem_d       = rem_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;
        wren_d      = (state_d == S_WR) || (state_d == S_FILL);
        rden_d      = (state_d == S_RD);
        ready_d     = (state_d == S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d = I_cmd_addr;
                    data_d = I_cmd_data;
                    rem_d  = I_cmd_count;
                end
            end
            S_FILL: begin
                if (go && rem_q != ONE) begin
                    addr_d = addr_q + ONE;
                    rem_d  = rem_q - ONE;
                end
            end
            S_RD_WAIT: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = I_mem_data;
            end
            default: ;
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            addr_q      <= '0;
            data_q      <= '0;
            rem_q       <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            wren_q      <= 1'b0;
            rden_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            addr_q      <= addr_d;
            data_q      <= data_d;
            rem_q       <= rem_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            wren_q      <= wren_d;
            rden_q      <= rden_d;
            ready_q     <= ready_d;
        end
    end

    assign O_cmd_ready = ready_q;
    assign O_busy      = ~ready_q;
    assign O_rsp_valid = rsp_valid_q;
    assign O_rsp_data  = rsp_data_q;
    assign O_mem_clock = I_clock;
    assign O_mem_addr  = addr_q;
    assign O_mem_data  = data_q;
    assign O_mem_wren  = wren_q & go;
    assign O_mem_rden  = rden_q & go;

endmodule

// File: tb/tb_vram_writer.sv
// tb_vram_writer: directed checks for vram_writer.
// Includes a small dpmem port-1 model for write/read-back.
module tb_vram_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        ready;
    logic [1:0]  op = 2'd0;
    logic [11:0] caddr = '0;
    logic [7:0]  cdata = '0;
    logic [11:0] ccount = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        busy;
    logic        mclk;
    logic [11:0] maddr;
    logic        wren;
    logic        rden;
    logic [7:0]  mwdata;
    logic [7:0]  mrdata = '0;
`ifdef VRAM_WRITER_VBLANK_GATE_EN
    logic        blank = 1'b1;
`endif

    logic [7:0] mem [4096] = '{default: 8'h00};
    int wr_cnt = 0;
    int checks = 0;
    int errors = 0;

    vram_writer dut (
        .I_clock    (clk),
        .I_reset    (rst),
        .I_cmd_valid(valid),
        .O_cmd_ready(ready),
        .I_cmd_op   (op),
        .I_cmd_addr (caddr),
        .I_cmd_data (cdata),
        .I_cmd_count(ccount),
        .O_rsp_valid(rsp_valid),
        .O_rsp_data (rsp_data),
        .O_busy     (busy),
`ifdef VRAM_WRITER_VBLANK_GATE_EN
        .I_vid_blank(blank),
`endif
        .O_mem_clock(mclk),
        .O_mem_addr (maddr),
        .O_mem_wren (wren),
        .O_mem_rden (rden),
        .O_mem_data (mwdata),
        .I_mem_data (mrdata)
    );

    always #5 clk = ~clk;

    // Port-1 memory model: synchronous write, one-cycle registered read
    always @(posedge clk) begin
        if (wren) begin
            mem[maddr] <= mwdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (rden) mrdata <= mem[maddr];
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [1:0] o, input logic [11:0] a,
                       input logic [7:0] d, input logic [11:0] n);
        valid  = 1'b1;
        op     = o;
        caddr  = a;
        cdata  = d;
        ccount = n;
    endtask

    logic [1:0]  q_op   [4];
    logic [11:0] q_addr [4];
    logic [7:0]  q_data [4];
    int          acc_cyc [4];

    initial begin
        int idx, nw, nr, ovl, nrsp, wr0;
        logic acc;
        logic [7:0]  rsp_seen;
        logic [11:0] ea;

        tick();
        tick();
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_wren", wren, 0);
        chk("rst_rden", rden, 0);
        chk("rst_addr", maddr, 0);
        chk("rst_data", mwdata, 0);
        rst = 1'b0;
        tick();

        // WRITE 0x123 <- 0xA5
        cmd(2'd0, 12'h123, 8'hA5, 12'h0);
        tick();
        valid = 1'b0;
        chk("wr_wren", wren, 1);
        chk("wr_addr", maddr, 12'h123);
        chk("wr_data", mwdata, 8'hA5);
        chk("wr_rden", rden, 0);
        chk("wr_busy", busy, 1);
        tick();
        chk("wr_wren_off", wren, 0);
        chk("wr_ready_back", ready, 1);

        // READ 0x123
        cmd(2'd2, 12'h123, 8'h00, 12'h0);
        tick();
        valid = 1'b0;
        chk("rd_rden", rden, 1);
        chk("rd_addr", maddr, 12'h123);
        chk("rd_wren", wren, 0);
        tick();
        chk("rd_rden_off", rden, 0);
        chk("rd_rsp_early", rsp_valid, 0);
        tick();
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rsp_data", rsp_data, 8'hA5);
        chk("rd_ready", ready, 1);
        tick();
        chk("rd_rsp_pulse", rsp_valid, 0);
        chk("rd_rsp_hold", rsp_data, 8'hA5);

        // FILL wrapping past the top of memory
        cmd(2'd1, 12'hFFE, 8'h3C, 12'd4);
        tick();
        valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ea = 12'hFFE + 12'(i);
            chk($sformatf("fill_wren%0d", i), wren, 1);
            chk($sformatf("fill_addr%0d", i), maddr, ea);
            chk($sformatf("fill_data%0d", i), mwdata, 8'h3C);
            chk($sformatf("fill_ready%0d", i), ready, 0);
            tick();
        end
        chk("fill_done_wren", wren, 0);
        chk("fill_done_ready", ready, 1);
        chk("fill_mem_ffe", mem[12'hFFE], 8'h3C);
        chk("fill_mem_001", mem[12'h001], 8'h3C);
        chk("fill_mem_002", mem[12'h002], 8'h00);

        // FILL with count 0 is a no-op
        wr0 = wr_cnt;
        cmd(2'd1, 12'h300, 8'h77, 12'd0);
        tick();
        valid = 1'b0;
        chk("fill0_ready", ready, 1);
        chk("fill0_wren", wren, 0);
        tick();
        chk("fill0_wren2", wren, 0);
        chk("fill0_writes", wr_cnt - wr0, 0);
        chk("fill0_mem", mem[12'h300], 8'h00);

        // Reset during the 3rd cycle of a long FILL
        wr0 = wr_cnt;
        cmd(2'd1, 12'h200, 8'h5A, 12'd100);
        tick();
        valid = 1'b0;
        chk("rfill_addr1", maddr, 12'h200);
        tick();
        chk("rfill_addr2", maddr, 12'h201);
        tick();
        chk("rfill_addr3", maddr, 12'h202);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rfill_wren_off", wren, 0);
        chk("rfill_ready", ready, 1);
        chk("rfill_addr_rst", maddr, 0);
        tick();
        chk("rfill_wren_off2", wren, 0);
        chk("rfill_writes", wr_cnt - wr0, 3);
        chk("rfill_mem202", mem[12'h202], 8'h5A);
        chk("rfill_mem203", mem[12'h203], 8'h00);

        // Back-to-back commands with valid held high
        q_op[0] = 2'd0; q_addr[0] = 12'h010; q_data[0] = 8'h11;
        q_op[1] = 2'd0; q_addr[1] = 12'h011; q_data[1] = 8'h22;
        q_op[2] = 2'd2; q_addr[2] = 12'h010; q_data[2] = 8'h00;
        q_op[3] = 2'd3; q_addr[3] = 12'h050; q_data[3] = 8'h99;
        idx = 0; nw = 0; nr = 0; ovl = 0; nrsp = 0; rsp_seen = '0;
        for (int i = 0; i < 4; i++) acc_cyc[i] = -1;
        cmd(q_op[0], q_addr[0], q_data[0], 12'd0);
        for (int c = 0; c < 20; c++) begin
            if (wren && rden) ovl++;
            if (wren) nw++;
            if (rden) nr++;
            if (rsp_valid) begin
                nrsp++;
                rsp_seen = rsp_data;
            end
            acc = valid && ready;
            if (acc) acc_cyc[idx] = c;
            tick();
            if (acc) begin
                idx++;
                if (idx < 4) cmd(q_op[idx], q_addr[idx], q_data[idx], 12'd0);
                else valid = 1'b0;
            end
        end
        chk("b2b_all_accepted", idx, 4);
        chk("b2b_acc0", acc_cyc[0], 0);
        chk("b2b_acc1", acc_cyc[1], 2);
        chk("b2b_acc2", acc_cyc[2], 4);
        chk("b2b_acc3", acc_cyc[3], 7);
        chk("b2b_overlap", ovl, 0);
        chk("b2b_wren_cycles", nw, 2);
        chk("b2b_rden_cycles", nr, 1);
        chk("b2b_rsp_count", nrsp, 1);
        chk("b2b_rsp_data", rsp_seen, 8'h11);
        chk("b2b_mem011", mem[12'h011], 8'h22);
        chk("b2b_op3_mem", mem[12'h050], 8'h00);

`ifdef VRAM_WRITER_VBLANK_GATE_EN
        // FILL 8 with blank high 3 cycles, low 5, then high
        nw = 0;
        ea = 12'h400;
        cmd(2'd1, 12'h400, 8'hC3, 12'd8);
        tick();
        valid = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            blank = (c <= 3) || (c >= 9);
            #1;
            chk($sformatf("gate_wren%0d", c), wren, blank);
            if (wren) begin
                chk($sformatf("gate_addr%0d", c), maddr, ea);
                ea = ea + 12'd1;
                nw++;
            end
            tick();
        end
        chk("gate_writes", nw, 8);
        chk("gate_ready", ready, 1);
        chk("gate_mem407", mem[12'h407], 8'hC3);
        chk("gate_mem408", mem[12'h408], 8'h00);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
